// File: rtl/hilo_mdu_if.sv
// EX-stage request bus and HI/LO result bus of the multiply/divide sequencer.
// start is a one-cycle request taken only while busy==0 and flush==0; there is no ready, busy is the stall.
interface hilo_mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [1:0]  dbg_state;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi_o, lo_o, dbg_state
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi_o, lo_o, dbg_state
  );
endinterface

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO owner: 32-step shift-add multiply / restoring divide, plus MTHI/MTLO writes.
// Operands are reduced to magnitudes on entry; signs are re-applied in FIN.
module hilo_mdu_ctrl #(
  parameter int ITER = 32
) (
  input  logic       clk,
  input  logic       resetn,
  hilo_mdu_if.slave  bus
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_acc;
  logic [31:0]   r_mcand;
  logic [31:0]   r_a_orig;
  logic          r_is_div;
  logic          r_neg;
  logic          r_rneg;
  logic          r_dz;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic          r_done;

  logic          w_accept;
  logic          w_signed;
  logic [31:0]   w_a_mag;
  logic [31:0]   w_b_mag;
  logic [32:0]   w_sum;
  logic [63:0]   w_mul_next;
  logic [32:0]   w_shift;
  logic [33:0]   w_diff;
  logic [63:0]   w_div_next;
  logic [63:0]   w_prod_fix;
  logic [31:0]   w_quot_fix;
  logic [31:0]   w_rem_fix;
  logic [31:0]   w_res_hi;
  logic [31:0]   w_res_lo;

  assign w_accept = bus.start && !bus.flush;
  assign w_signed = !bus.op[0];
  assign w_a_mag  = (w_signed && bus.a[31]) ? -bus.a : bus.a;
  assign w_b_mag  = (w_signed && bus.b[31]) ? -bus.b : bus.b;

  // Multiply: r_acc = {partial product, remaining multiplier bits}.
  assign w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : 33'd0);
  assign w_mul_next = {w_sum, r_acc[31:1]};

  // Divide: r_acc = {partial remainder, dividend bits shifting into quotient}.
  assign w_shift    = {r_acc[63:32], r_acc[31]};
  assign w_diff     = {1'b0, w_shift} - {2'b00, r_mcand};
  assign w_div_next = w_diff[33] ? {w_shift[31:0], r_acc[30:0], 1'b0}
                                 : {w_diff[31:0],  r_acc[30:0], 1'b1};

  assign w_prod_fix = r_neg  ? -r_acc        : r_acc;
  assign w_quot_fix = r_neg  ? -r_acc[31:0]  : r_acc[31:0];
  assign w_rem_fix  = r_rneg ? -r_acc[63:32] : r_acc[63:32];

  always_comb begin
    w_res_hi = w_prod_fix[63:32];
    w_res_lo = w_prod_fix[31:0];
    if (r_is_div) begin
      if (r_dz) begin
        w_res_hi = r_a_orig;
        w_res_lo = 32'hFFFF_FFFF;
      end else begin
        w_res_hi = w_rem_fix;
        w_res_lo = w_quot_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (bus.op < 3'd4)) w_next = S_CALC;
      S_CALC: begin
        if (bus.flush)                      w_next = S_IDLE;
        else if (r_cnt == CW'(ITER - 1))    w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_a_orig <= '0;
      r_is_div <= 1'b0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (bus.op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                r_cnt    <= '0;
                r_is_div <= bus.op[1];
                r_a_orig <= bus.a;
                r_neg    <= w_signed && (bus.a[31] ^ bus.b[31]);
                r_rneg   <= w_signed && bus.a[31] && bus.op[1];
                r_dz     <= bus.op[1] && (bus.b == 32'd0);
                r_acc    <= {32'd0, (bus.op[1] ? w_a_mag : w_b_mag)};
                r_mcand  <= bus.op[1] ? w_b_mag : w_a_mag;
              end
              3'd4:    r_hi <= bus.a;
              3'd5:    r_lo <= bus.a;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          if (!bus.flush) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= r_is_div ? w_div_next : w_mul_next;
          end
        end
        S_FIN: begin
          if (!bus.flush) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.hi_o      = r_hi;
  assign bus.lo_o      = r_lo;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Randomized bench for hilo_mdu_ctrl against a cycle-count reference model using native arithmetic.
module tb_hilo_mdu_ctrl;
  logic clk;
  logic resetn;
  hilo_mdu_if bus ();

  hilo_mdu_ctrl #(.ITER(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_cnt;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  logic        m_done;

  function automatic logic [63:0] model_res(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    logic [63:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = 64'(sa / sb);
        r = 64'(sa % sb);
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_cnt  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 0) begin
        if (bus.flush) m_cnt <= 0;
        else begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) begin
            m_hi   <= m_pend[63:32];
            m_lo   <= m_pend[31:0];
            m_done <= 1'b1;
          end
        end
      end else if (bus.start && !bus.flush) begin
        if (bus.op < 3'd4) begin
          m_pend <= model_res(bus.op, bus.a, bus.b);
          m_cnt  <= 33;
        end else if (bus.op == 3'd4) m_hi <= bus.a;
        else if (bus.op == 3'd5)     m_lo <= bus.a;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("busy", {31'd0, bus.busy}, {31'd0, (m_cnt > 0)});
    chk("done", {31'd0, bus.done}, {31'd0, m_done});
    chk("hi_o", bus.hi_o, m_hi);
    chk("lo_o", bus.lo_o, m_lo);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.start = 1'b0;
    bus.op    = 3'd7;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
  endtask

  task automatic run_op(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] exp_hi, logic [31:0] exp_lo, string name);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, n, 34);
    chk({name, "_hi"}, bus.hi_o, exp_hi);
    chk({name, "_lo"}, bus.lo_o, exp_lo);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int saw_done;
    drive_idle();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hi", bus.hi_o, 32'd0);
    chk("reset_lo", bus.lo_o, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    resetn = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1m1");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
    run_op(3'd3, 32'd7,         32'd2,        32'd1,         32'd3,         "divu_7by2");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, "div_ovf");
    run_op(3'd3, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, "divu_by0");

    // MTHI then MTLO back to back
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("mthi_hi", bus.hi_o, 32'hA5A5_A5A5);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    bus.op = 3'd5; bus.a = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mtlo_lo", bus.lo_o, 32'h5A5A_5A5A);
    chk("mtlo_done", {31'd0, bus.done}, 32'd0);

    // MULT with an ignored MTLO while busy, then flushed at iteration 10
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.op = 3'd5; bus.a = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("flush_busy_before", {31'd0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy_after", {31'd0, bus.busy}, 32'd0);
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) saw_done++;
    end
    chk("flush_no_done", saw_done, 0);
    chk("flush_hi", bus.hi_o, 32'hA5A5_A5A5);
    chk("flush_lo", bus.lo_o, 32'h5A5A_5A5A);

    // Asynchronous reset at iteration 20
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("areset_busy", {31'd0, bus.busy}, 32'd0);
    chk("areset_done", {31'd0, bus.done}, 32'd0);
    chk("areset_hi", bus.hi_o, 32'd0);
    chk("areset_lo", bus.lo_o, 32'd0);
    @(negedge clk);
    #1 resetn = 1'b1;

    // Random traffic, including start while busy and flushes
    repeat (3000) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 1) == 1);
      bus.op    = 3'($urandom_range(0, 7));
      bus.a     = rand_operand();
      bus.b     = rand_operand();
      bus.flush = ($urandom_range(0, 31) == 0);
    end
    @(negedge clk);
    drive_idle();
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer that owns the architectural HI/LO register pair for the MIPS-32 core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX and runs a 32-iteration shift-add multiply or restoring divide. While an operation is in flight it holds the pipeline stall, then commits to HI/LO. MFHI/MFLO read hi_o/lo_o directly.

Parameters:
ITER, 32, iterations per mul/div operation (fixed to operand width)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  request valid from EX; sampled only in IDLE
op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no effect
a  input  32  rs operand (multiplicand / dividend / MTHI-MTLO data)
b  input  32  rt operand (multiplier / divisor)
flush  input  1  exception/flush; aborts in-flight operation
busy  output  1  high while a mul/div is in flight; drives pipeline stall
done  output  1  one-cycle pulse when a mul/div commits to HI/LO
hi_o  output  32  architectural HI
lo_o  output  32  architectural LO

Behaviour:
- Reset (resetn=0, async): state=IDLE, hi_o=0, lo_o=0, done=0, busy=0, iteration counter=0, internal accumulators=0. Reset mid-operation discards it with no HI/LO write.
- States: IDLE, CALC, FIN. busy = (state != IDLE), decoded from the state register.
- IDLE, start=1, flush=0:
  - op 0-3: latch |a|, |b| (magnitudes only for op 0/2), result sign, remainder sign (=sign of a), divide-by-zero flag (b==0, ops 2/3). Counter=0. Go to CALC.
  - op 4: hi_o<=a next edge. op 5: lo_o<=a next edge. Stay in IDLE, no busy, no done.
  - op 6/7: no effect.
- CALC: one iteration per clock.
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring, one quotient bit per cycle, 33-bit partial remainder.
  - Counter increments each cycle; on the edge where counter==31, go to FIN.
- FIN, one cycle: apply sign correction, write {hi_o,lo_o}, assert done for the following cycle, return to IDLE.
  - Multiply: {HI,LO} = 64-bit product, two's-complement negated if the result sign is set.
  - Divide: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - Divide by zero: HI=a (original), LO=0xFFFFFFFF, regardless of signedness.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Latency: start accepted at edge T0. busy is high from T0 to T33. HI/LO are updated and done=1 in the cycle after T33. The next start is accepted at T34, the same cycle done is high.
- start while busy: ignored. The pipeline is stalled, so the same request is not re-presented.
- flush in CALC or FIN: next state IDLE, HI/LO unchanged, done stays 0. A flush coinciding with the FIN edge wins, so no write occurs.
- flush with start in IDLE: flush wins; nothing is accepted, including MTHI/MTLO.
- done is never asserted for MTHI/MTLO and is low except for its single-cycle pulse.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> busy for 34 cycles, then done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; MULT with the same operands -> HI=0, LO=1.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7, b=2 -> LO=3, HI=1; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- DIVU a=0x1234, b=0 -> after 34 cycles HI=0x1234, LO=0xFFFFFFFF, done=1.
- MTHI a=0xA5A5A5A5, then MTLO a=0x5A5A5A5A on consecutive cycles -> hi_o/lo_o update next edge, busy=0, done=0. Issue MTLO while busy -> ignored.
- MULT started, flush at iteration 10 -> busy drops next edge, HI/LO keep prior values, no done. Separately, resetn low at iteration 20 -> all outputs 0 immediately (asynchronously).
